pipelined_alu_hs: RTL

- Parametrised, registered successor to the 4-bit combinational ALU.
- One shared datapath of WIDTH bits with a 3-bit opcode instead of a one-hot decoded select. Supports ADD, SUB, CMP, AND, OR, XOR and a multi-cycle unsigned shift-add MUL.
- Sits between an operand producer and a result consumer, using valid/ready handshakes on both sides.
- Results and flags are held stable until the consumer accepts them.

---
 rtl/pipelined_alu_hs.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipelined_alu_hs.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops plus a fixed-latency shift-add multiplier.
module pipelined_alu_hs #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 greater,
  output logic                 equal,
  output logic                 less,
  output logic                 zero,
  output logic                 illegal
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned W1 = WIDTH + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q;
  logic [RW-1:0]      prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RW-1:0]      result_q;
  logic               out_valid_q;
  logic               carry_q, greater_q, equal_q, less_q, zero_q, illegal_q;

  logic               fire_c;
  logic [W1-1:0]      add_c, sub_c, mac_c;
  logic [RW-1:0]      sc_res_c, prod_next_c;
  logic               sc_carry_c;

  // A retiring result frees the slot in the same cycle, so no bubble between ops.
  assign in_ready = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign fire_c   = in_valid && in_ready;

  // Single-cycle results and one shift-add multiplier step.
  always_comb begin
    add_c      = {1'b0, a} + {1'b0, b};
    sub_c      = {1'b0, a} + {1'b0, ~b} + W1'(1);
    sc_res_c   = '0;
    sc_carry_c = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res_c   = RW'(add_c[WIDTH-1:0]);
        sc_carry_c = add_c[WIDTH];
      end
      OP_SUB: begin
        sc_res_c   = RW'(sub_c[WIDTH-1:0]);
        sc_carry_c = sub_c[WIDTH];
      end
      OP_AND:  sc_res_c = RW'(a & b);
      OP_OR:   sc_res_c = RW'(a | b);
      OP_XOR:  sc_res_c = RW'(a ^ b);
      default: sc_res_c = '0;
    endcase
    mac_c       = {1'b0, prod_q[RW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : W1'(0));
    prod_next_c = {mac_c, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prod_q      <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      greater_q   <= 1'b0;
      equal_q     <= 1'b0;
      less_q      <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (fire_c) begin
      greater_q <= (a > b);
      equal_q   <= (a == b);
      less_q    <= (a < b);
      if (op == OP_MUL) begin
        state_q     <= S_BUSY;
        out_valid_q <= 1'b0;
        prod_q      <= {WIDTH'(0), b};
        mcand_q     <= a;
        cnt_q       <= '0;
        carry_q     <= 1'b0;
        illegal_q   <= 1'b0;
      end else begin
        state_q     <= S_DONE;
        out_valid_q <= 1'b1;
        result_q    <= sc_res_c;
        carry_q     <= sc_carry_c;
        zero_q      <= (sc_res_c == '0);
        illegal_q   <= (op == OP_ILL);
      end
    end else begin
      case (state_q)
        S_BUSY: begin
          prod_q <= prod_next_c;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= prod_next_c;
            zero_q      <= (prod_next_c == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign greater   = greater_q;
  assign equal     = equal_q;
  assign less      = less_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
